// File: rtl/divider_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Division by zero yields all-ones quotient, remainder = A.
module divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;
  logic             r_zero;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // The held remainder is always below the divisor (or a prefix of A when B = 0),
  // so it fits WIDTH bits; only the shifted working value needs WIDTH+1.
  assign w_rem_shift = {r_rem, r_dividend[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_divisor};
  // Top bit of the difference is the borrow: clear means shifted >= divisor.
  assign w_ge        = ~w_diff[WIDTH];
  assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_quo_next  = {r_dividend[WIDTH-2:0], w_ge};
  assign w_last      = (r_count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: busy decodes directly from the registered state.
  always_comb begin
    busy = (r_state == S_RUN);
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_zero      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= A;
            r_divisor  <= B;
            r_rem      <= '0;
            r_count    <= '0;
            r_zero     <= (B == '0);
          end
        end
        S_RUN: begin
          r_rem      <= w_rem_next;
          r_dividend <= w_quo_next;
          r_count    <= r_count + CW'(1);
          if (w_last) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_dbz       <= r_zero;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign Quotient    = r_quotient;
  assign Remainder   = r_remainder;

endmodule

// File: tb/tb_divider_4bit.sv
// Scoreboard bench for divider_4bit: the driver queues expected results, an
// independent monitor pops and compares on every done pulse, including latency.
module tb_divider_4bit;

  localparam int W       = 4;
  localparam int LATENCY = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] quo;
  logic [W-1:0] rem;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  divider_4bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dz),
    .Quotient    (quo),
    .Remainder   (rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient",    quo, e.q);
        check("remainder",   rem, e.r);
        check("div_by_zero", dz,  e.dz);
        check("latency",     cyc - e.edge_no, LATENCY);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Called at a negedge: start is sampled at the next posedge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
  endtask

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
    exp_t e;
    e.q       = q;
    e.r       = r;
    e.dz      = d;
    e.edge_no = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
    @(negedge clk);
    drive(a, b);
    push(q, r, d);
    @(negedge clk);
    start = 1'b0;
    check("busy_running", busy, 1);
    wait_drain(20);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_dz"},        dz,   0);
    check({tag, "_quotient"},  quo,  0);
    check({tag, "_remainder"}, rem,  0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] eq;
    logic [W-1:0] er;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed vectors.
    run_one(4'd8,  4'd2, 4'd4,  4'd0,  1'b0);
    run_one(4'd10, 4'd3, 4'd3,  4'd1,  1'b0);
    run_one(4'd15, 4'd0, 4'd15, 4'd15, 1'b1);

    // start while busy is ignored: only the 9/4 result may appear.
    @(negedge clk);
    drive(4'd9, 4'd4);
    push(4'd2, 4'd1, 1'b0);
    @(negedge clk);
    drive(4'd1, 4'd1);
    check("busy_ignore", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
    repeat (6) @(negedge clk);
    check("idle_after_ignore", busy, 0);

    // Leave non-zero results (including div_by_zero) so the reset clear is visible.
    run_one(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);

    // Abort 13/5 with rst during the second busy cycle; no done may follow.
    @(negedge clk);
    drive(4'd13, 4'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("abort");
    repeat (8) @(negedge clk);
    run_one(4'd13, 4'd5, 4'd2, 4'd3, 1'b0);

    // Exhaustive back-to-back: each new start is raised during the done cycle.
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'd15;
          er = W'(a);
        end else begin
          eq = W'(a / b);
          er = W'(a % b);
        end
        drive(W'(a), W'(b));
        push(eq, er, (b == 0));
        @(negedge clk);
        start = 1'b0;
        wait_done(12);
      end
    end
    start = 1'b0;
    wait_drain(20);
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
